// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO of bytes from the core,
// drained back-to-back onto a registered tx line.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DEPTH_LOG2   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            data_in,
   input  logic                  data_valid,
   output logic                  tx,
   output logic                  busy,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  overflow
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CNT_W  = DEPTH_LOG2 + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(DEPTH);

   logic [1:0]            state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [2:0]            bit_q, bit_d;
   logic [7:0]            shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            mem_q [DEPTH];
   logic [7:0]            mem_d [DEPTH];

   logic pop;
   logic push;
   logic bit_end;
   logic fifo_has_data;

   assign bit_end       = (baud_q == BAUD_LAST);
   assign fifo_has_data = (count_q != '0);

   // Transmit FSM; tx_d is the value the pin will carry after this edge.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (fifo_has_data) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (fifo_has_data) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   // A full FIFO still accepts a byte when the FSM frees a slot on the same edge.
   always_comb begin
      mem_d      = mem_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      push       = data_valid && ((count_q != COUNT_FULL) || pop);
      overflow_d = overflow_q | (data_valid & ~push);
      if (push) begin
         mem_d[wr_ptr_q] = data_in;
         wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         mem_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = (state_q != IDLE) || fifo_has_data;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;

endmodule
